dmem_port: RTL and testbench

Data-memory responder for the pipeline's memory stage: it accepts the load/store request the memory stage presents (address, size, store data) and returns load data or a fault. It services each request over a configurable number of wait states, holding the pipeline with `stall` (wired to upstream `clk_en` as `~stall`). It also drops in-flight accesses when writeback signals an exception or rfe flush. It sits between the memory-stage register and the writeback stage and owns the data SRAM.

---
 rtl/dmem_pkg.sv | 45 ++++
 rtl/dmem_sram.sv | 32 +++
 rtl/dmem_port.sv | 209 ++++++++++++++++++++
 tb/tb_dmem_port.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, codes and lane helpers for the data-memory port
// Contents: state_t (IDLE/WAIT/RESP), FAULT_* response codes, SIZE_* encodings,
//           lane_mask(size, addr_lo) byte-enable generator,
//           load_extend(word, size, addr_lo, sext) load alignment and extension.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_RANGE    = 2'd2;
    localparam logic [1:0] FAULT_SIZE     = 2'd3;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Byte lanes touched by an aligned access of the given size.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
            SIZE_HALF: lane_mask = 4'b0011 << addr_lo;
            SIZE_WORD: lane_mask = 4'b1111;
            default:   lane_mask = 4'b0000;
        endcase
    endfunction

    // Right-justify the addressed bytes of a word and zero/sign extend them.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] addr_lo, input logic sext);
        logic [31:0] sh;
        sh = word >> {addr_lo, 3'b000};
        case (size)
            SIZE_BYTE: load_extend = {{24{sext & sh[7]}}, sh[7:0]};
            SIZE_HALF: load_extend = {{16{sext & sh[15]}}, sh[15:0]};
            SIZE_WORD: load_extend = word;
            default:   load_extend = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - synchronous single-port data array with byte write enables
// Ports: clk; en access strobe; we[3:0] byte-lane write enables (all zero = read);
//        addr word address; wdata lane-aligned write data; rdata registered read data.
// The array has no reset; rdata holds its value until the next read.
module dmem_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (we == 4'b0000) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_port.sv
// rtl/dmem_port.sv - memory-stage load/store responder with wait states and fault checks
// Parameters: DEPTH_WORDS array size in words; WAIT_CYCLES stall cycles per access (0..15).
// Ports: clk, rst (async, active-high);
//        req_valid/req_store/req_size/req_signed/req_addr/req_wdata request from memory stage;
//        flush cancels a pending access; stall holds the upstream pipeline;
//        rsp_valid one-cycle response, rsp_rdata load data, rsp_fault FAULT_* code.
// Build option: DMEM_STORE_BUFFER_EN adds a one-entry posted store buffer.
module dmem_port
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_fault
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_LOAD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t         state, state_next;
    logic [3:0]     cnt;
    logic           store_q, signed_q;
    logic [1:0]     size_q, fault_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;

    logic [1:0]     req_fault;
    logic           accept, accept_legal, buffer_store, sb_busy;
    logic           wait_hit, direct_hit;
    logic           sram_en;
    logic [3:0]     sram_we;
    logic [AW-1:0]  sram_addr;
    logic [31:0]    sram_wdata, sram_rdata;

    // Size is checked first, then alignment, then range.
    always_comb begin
        req_fault = FAULT_NONE;
        if (req_size == 2'd3) begin
            req_fault = FAULT_SIZE;
        end else if ((req_size == SIZE_HALF && req_addr[0]) ||
                     (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)) begin
            req_fault = FAULT_MISALIGN;
        end else if ({1'b0, req_addr} >= ADDR_LIMIT) begin
            req_fault = FAULT_RANGE;
        end
    end

    // New requests are taken in IDLE and also in the RESP cycle.
    assign accept       = (state != WAIT) && !sb_busy && req_valid && !flush;
    assign accept_legal = accept && (req_fault == FAULT_NONE);

`ifdef DMEM_STORE_BUFFER_EN
    logic          sb_valid;
    logic [3:0]    sb_cnt;
    logic [AW-1:0] sb_addr;
    logic [3:0]    sb_we;
    logic [31:0]   sb_wdata;
    logic          drain_hit;

    assign buffer_store = accept_legal && req_store;
    assign sb_busy      = sb_valid;
    assign drain_hit    = sb_valid && (sb_cnt == 4'd0);

    // Drain runs WAIT_CYCLES+1 cycles and ignores flush: the store already responded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_valid <= 1'b0;
            sb_cnt   <= 4'd0;
            sb_addr  <= '0;
            sb_we    <= 4'b0000;
            sb_wdata <= 32'h0000_0000;
        end else if (buffer_store) begin
            sb_valid <= 1'b1;
            sb_cnt   <= 4'(WAIT_CYCLES);
            sb_addr  <= req_addr[AW+1:2];
            sb_we    <= lane_mask(req_size, req_addr[1:0]);
            sb_wdata <= req_wdata << {req_addr[1:0], 3'b000};
        end else if (drain_hit) begin
            sb_valid <= 1'b0;
        end else if (sb_valid) begin
            sb_cnt <= sb_cnt - 4'd1;
        end
    end
`else
    assign buffer_store = 1'b0;
    assign sb_busy      = 1'b0;
`endif

    // With zero wait states the array is accessed on the accept edge itself.
    assign wait_hit   = (state == WAIT) && !flush && (cnt == 4'd0);
    assign direct_hit = accept_legal && !buffer_store && (WAIT_CYCLES == 0);

    always_comb begin
        sram_en    = wait_hit || direct_hit;
        sram_addr  = addr_q[AW+1:2];
        sram_we    = store_q ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;
        sram_wdata = wdata_q << {addr_q[1:0], 3'b000};
        if (direct_hit) begin
            sram_addr  = req_addr[AW+1:2];
            sram_we    = req_store ? lane_mask(req_size, req_addr[1:0]) : 4'b0000;
            sram_wdata = req_wdata << {req_addr[1:0], 3'b000};
        end
`ifdef DMEM_STORE_BUFFER_EN
        if (drain_hit) begin
            sram_en    = 1'b1;
            sram_addr  = sb_addr;
            sram_we    = sb_we;
            sram_wdata = sb_wdata;
        end
`endif
    end

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (sram_wdata),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, RESP: begin
                state_next = IDLE;
                if (accept) begin
                    if (!accept_legal || buffer_store || WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 4'd0;
            store_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= SIZE_BYTE;
            addr_q   <= '0;
            wdata_q  <= 32'h0000_0000;
            fault_q  <= FAULT_NONE;
        end else begin
            if (accept) begin
                store_q  <= req_store;
                signed_q <= req_signed;
                size_q   <= req_size;
                addr_q   <= req_addr[AW+1:0];
                wdata_q  <= req_wdata;
                fault_q  <= req_fault;
            end
            if (accept && state_next == WAIT) begin
                cnt <= CNT_LOAD;
            end else if (state == WAIT) begin
                cnt <= (flush || cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
            end
        end
    end

    // A request blocked behind the store buffer also stalls, even in RESP.
    always_comb begin
        rsp_valid = (state == RESP);
        rsp_fault = (state == RESP) ? fault_q : FAULT_NONE;
        rsp_rdata = 32'h0000_0000;
        if (state == RESP && !store_q && fault_q == FAULT_NONE) begin
            rsp_rdata = load_extend(sram_rdata, size_q, addr_q[1:0], signed_q);
        end
        stall = (state == WAIT) ||
                (state == IDLE && accept_legal && !buffer_store && WAIT_CYCLES > 0) ||
                (sb_busy && req_valid && !flush && state != WAIT);
    end

endmodule

// File: tb/tb_dmem_port.sv
// tb/tb_dmem_port.sv - directed self-checking bench for dmem_port
module tb_dmem_port;
    import dmem_pkg::*;

    localparam int DEPTH = 1024;
    localparam int W     = 2;
`ifdef DMEM_STORE_BUFFER_EN
    localparam int ST_LAT = 1, ST_STALLS = 0, ST_ACC = 0;
`else
    localparam int ST_LAT = W + 1, ST_STALLS = W, ST_ACC = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, req_valid, req_store, req_signed, flush;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_port #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .flush(flush), .stall(stall), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
    endtask

    // Issue one request from IDLE; report accept-cycle stall, latency, stalls after accept, response.
    task automatic run_req(input logic st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic acc_stall, output int lat, output int stalls,
                           output logic [31:0] rd, output logic [1:0] ft);
        drive(st, sz, sg, a, wd);
        #1;
        acc_stall = stall;
        tick();
        req_valid = 1'b0;
        lat = 0; stalls = 0; rd = 32'h0; ft = 2'd0;
        for (int i = 1; i <= 16; i++) begin
            if (rsp_valid) begin
                lat = i; rd = rsp_rdata; ft = rsp_fault;
                break;
            end
            if (stall) stalls++;
            tick();
        end
        tick();
    endtask

    task automatic store_op(input string tag, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
        logic acc; int lat, stalls; logic [31:0] rd; logic [1:0] ft;
        run_req(1'b1, sz, 1'b0, a, wd, acc, lat, stalls, rd, ft);
        check({tag, " fault"}, 32'(ft), 32'(FAULT_NONE));
        check({tag, " lat"}, lat, ST_LAT);
        check({tag, " stalls"}, stalls, ST_STALLS);
        check({tag, " acc_stall"}, 32'(acc), ST_ACC);
`ifdef DMEM_STORE_BUFFER_EN
        repeat (W + 1) tick();
`endif
    endtask

    task automatic load_chk(input string tag, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] exp);
        logic acc; int lat, stalls; logic [31:0] rd; logic [1:0] ft;
        run_req(1'b0, sz, sg, a, 32'h0, acc, lat, stalls, rd, ft);
        check({tag, " data"}, rd, exp);
        check({tag, " fault"}, 32'(ft), 32'(FAULT_NONE));
        check({tag, " lat"}, lat, W + 1);
        check({tag, " stalls"}, stalls, W);
    endtask

    task automatic fault_chk(input string tag, input logic [1:0] sz, input logic [31:0] a,
                             input logic [1:0] exp);
        logic acc; int lat, stalls; logic [31:0] rd; logic [1:0] ft;
        run_req(1'b0, sz, 1'b0, a, 32'h0, acc, lat, stalls, rd, ft);
        check({tag, " fault"}, 32'(ft), 32'(exp));
        check({tag, " data"}, rd, 32'h0);
        check({tag, " lat"}, lat, 1);
        check({tag, " stalls"}, stalls + int'(acc), 0);
    endtask

    initial begin
        int n, pulses;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = SIZE_WORD;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst stall", 32'(stall), 0);
        check("rst rsp_valid", 32'(rsp_valid), 0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);
        check("rst rsp_fault", 32'(rsp_fault), 32'(FAULT_NONE));
        rst = 1'b0;
        tick();

        store_op("st40", SIZE_WORD, 32'h40, 32'hDEADBEEF);
        load_chk("lb43 signed", SIZE_BYTE, 1'b1, 32'h43, 32'hFFFFFFDE);
        load_chk("lhu42", SIZE_HALF, 1'b0, 32'h42, 32'h0000DEAD);
        load_chk("lh40 signed", SIZE_HALF, 1'b1, 32'h40, 32'hFFFFBEEF);
        load_chk("lbu40", SIZE_BYTE, 1'b0, 32'h40, 32'h000000EF);
        load_chk("lw40", SIZE_WORD, 1'b0, 32'h40, 32'hDEADBEEF);

        fault_chk("lh41 misalign", SIZE_HALF, 32'h41, FAULT_MISALIGN);
        fault_chk("lw42 misalign", SIZE_WORD, 32'h42, FAULT_MISALIGN);
        fault_chk("lw range", SIZE_WORD, 32'(DEPTH * 4), FAULT_RANGE);
        fault_chk("size3", 2'd3, 32'h40, FAULT_SIZE);

        store_op("stlast", SIZE_WORD, 32'(DEPTH * 4 - 4), 32'h600DCAFE);
        load_chk("lwlast", SIZE_WORD, 1'b0, 32'(DEPTH * 4 - 4), 32'h600DCAFE);

        store_op("sb41", SIZE_BYTE, 32'h41, 32'h00000055);
        store_op("sh42", SIZE_HALF, 32'h42, 32'h00001234);
        load_chk("lw40 merged", SIZE_WORD, 1'b0, 32'h40, 32'h123455EF);
        load_chk("lb43 positive", SIZE_BYTE, 1'b1, 32'h43, 32'h00000012);

        store_op("st80", SIZE_WORD, 32'h80, 32'hA5A5A5A5);
`ifndef DMEM_STORE_BUFFER_EN
        drive(1'b1, SIZE_WORD, 1'b0, 32'h80, 32'h11223344);
        tick();
        req_valid = 1'b0;
        check("flush wait stall", 32'(stall), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) pulses++;
            tick();
        end
        check("flush no rsp", pulses, 0);
        check("flush idle stall", 32'(stall), 0);
        load_chk("lw80 after flush", SIZE_WORD, 1'b0, 32'h80, 32'hA5A5A5A5);
`endif

        store_op("stC0", SIZE_WORD, 32'hC0, 32'h01020304);
        drive(1'b1, SIZE_WORD, 1'b0, 32'hC0, 32'h0BADF00D);
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst stall", 32'(stall), 0);
        check("midrst rsp_valid", 32'(rsp_valid), 0);
        check("midrst rsp_rdata", rsp_rdata, 32'h0);
        check("midrst rsp_fault", 32'(rsp_fault), 32'(FAULT_NONE));
        tick();
        rst = 1'b0;
        tick();
        load_chk("lwC0 after rst", SIZE_WORD, 1'b0, 32'hC0, 32'h01020304);

        drive(1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0);
        tick();
        req_valid = 1'b0;
        n = 0;
        for (int i = 1; i <= 16; i++) begin
            if (rsp_valid) begin n = i; break; end
            tick();
        end
        check("b2b first lat", n, W + 1);
        check("b2b first data", rsp_rdata, 32'h123455EF);
        drive(1'b0, SIZE_WORD, 1'b0, 32'h80, 32'h0);
        #1;
        check("b2b resp stall", 32'(stall), 0);
        tick();
        req_valid = 1'b0;
        n = 0;
        for (int i = 1; i <= 16; i++) begin
            if (rsp_valid) begin n = i; break; end
            tick();
        end
        check("b2b second lat", n, W + 1);
        check("b2b second data", rsp_rdata, 32'hA5A5A5A5);
        tick();

`ifdef DMEM_STORE_BUFFER_EN
        drive(1'b1, SIZE_WORD, 1'b0, 32'h100, 32'hCAFEF00D);
        #1;
        check("sbuf accept stall", 32'(stall), 0);
        tick();
        check("sbuf store rsp", 32'(rsp_valid), 1);
        drive(1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0);
        #1;
        check("sbuf load blocked", 32'(stall), 1);
        n = 0;
        for (int i = 2; i <= 30; i++) begin
            tick();
            if (rsp_valid) begin n = i; break; end
        end
        req_valid = 1'b0;
        check("sbuf load lat", n, 2 * W + 3);
        check("sbuf load data", rsp_rdata, 32'hCAFEF00D);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
